// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the r100 load/store unit: funct3 codes, FSM states
// and the access-size decode used by both the controller and the aligner.
package lsu_ctrl_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Undefined funct3 codes (011, 110, 111) fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// for the request side, lane select and sign/zero extension for load data.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext
);

    logic [1:0]  lane_off;
    logic [31:0] lane;

    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        lane_off      = 2'b00;
        be            = 4'b1111;
        wdata_steered = wdata;
        unique case (lsu_size(funct3))
            SZ_BYTE: begin
                lane_off      = addr_lo;
                be            = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
            end
            // Halfwords only ever sit on lanes 0 or 2; addr[0] is dropped.
            SZ_HALF: begin
                lane_off      = {addr_lo[1], 1'b0};
                be            = 4'b0011 << lane_off;
                wdata_steered = {2{wdata[15:0]}};
            end
            default: begin
                lane_off      = 2'b00;
                be            = 4'b1111;
                wdata_steered = wdata;
            end
        endcase
    end

    assign lane = rdata >> {lane_off, 3'b000};

    always_comb begin
        rdata_ext = lane;
        case (funct3)
            LSU_B:   rdata_ext = {{24{lane[7]}}, lane[7:0]};
            LSU_H:   rdata_ext = {{16{lane[15]}}, lane[15:0]};
            LSU_BU:  rdata_ext = {24'h0, lane[7:0]};
            LSU_HU:  rdata_ext = {16'h0, lane[15:0]};
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: IDLE/BUSY/RESP FSM, memory handshake and
// ack timeout. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses early.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_fault_q, resp_fault_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             misaligned;
    logic             idle;
    logic [2:0]       al_funct3;
    logic [1:0]       al_off;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        unique case (lsu_size(req_funct3))
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            default: misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // One aligner serves both ends: live request fields while idle, captured fields afterwards.
    assign idle      = (state_q == ST_IDLE);
    assign al_funct3 = idle ? req_funct3 : funct3_q;
    assign al_off    = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3        (al_funct3),
        .addr_lo       (al_off),
        .wdata         (req_wdata),
        .rdata         (mem_rdata),
        .be            (al_be),
        .wdata_steered (al_wdata),
        .rdata_ext     (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && misaligned) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else if (req_valid) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    funct3_d    = req_funct3;
                    off_d       = req_addr[1:0];
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_be_d    = al_be;
                    mem_wdata_d = al_wdata;
                end
            end
            // An ack on the last counted cycle takes priority over the timeout.
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? 32'h0 : al_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
